// File: rtl/vmem_pkg.sv
// Shared state encoding and lane geometry for the vector memory sequencer.
package vmem_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain,
        StDone
    } vmem_state_t;

endpackage

// File: rtl/vmem_lane_assembler.sv
// Lane-indexed byte capture register that builds the 128-bit vector load result.
module vmem_lane_assembler
    import vmem_pkg::*;
#(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cap_en,
    input  logic [IDX_W-1:0]        lane,
    input  logic [LANE_W-1:0]       lane_byte,
    output logic [LANES*LANE_W-1:0] vec_data
);

    // Bytes not being captured keep their value, so a store leaves the last load intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_data <= '0;
        end else if (cap_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane == IDX_W'(i)) begin
                    vec_data[i*LANE_W +: LANE_W] <= lane_byte;
                end
            end
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serializes vector loads/stores into byte accesses on one RAM port, arbitrating with scalar ops.
// Define VMEM_WRAP_GUARD_EN to reject vector requests whose byte span wraps past the top of RAM.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scalar_req,
    input  logic                    scalar_we,
    input  logic [ADDR_W-1:0]       scalar_addr,
    input  logic [LANE_W-1:0]       scalar_wdata,
    output logic                    scalar_gnt,
    output logic [LANE_W-1:0]       scalar_rdata,
    input  logic                    vec_req,
    input  logic                    vec_we,
    input  logic [ADDR_W-1:0]       vec_addr,
    input  logic [LANES*LANE_W-1:0] vec_wdata,
    output logic [LANES*LANE_W-1:0] vec_rdata,
    output logic                    vec_done,
    output logic                    vec_err,
    output logic                    stall,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [LANE_W-1:0]       ram_wdata,
    output logic                    ram_wren,
    input  logic [LANE_W-1:0]       ram_q
);

    localparam int unsigned      IDX_W     = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    vmem_state_t             state_q;
    logic [IDX_W-1:0]        lane_q;
    logic [ADDR_W-1:0]       base_q;
    logic                    we_q;
    logic [LANES*LANE_W-1:0] wdata_q;
    logic                    cap_en_q;
    logic [IDX_W-1:0]        cap_lane_q;

    logic idle;
    logic wrap_hit;
    logic err_now;
    logic vec_accept;

    assign idle = (state_q == StIdle);

`ifdef VMEM_WRAP_GUARD_EN
    logic [ADDR_W:0] vec_end;
    assign vec_end  = {1'b0, vec_addr} + (ADDR_W + 1)'(LANES - 1);
    assign wrap_hit = vec_end[ADDR_W];
`else
    assign wrap_hit = 1'b0;
`endif

    // Scalar wins the port in IDLE; a vector request seen alongside it stays pending.
    assign err_now    = idle & vec_req & ~scalar_req & wrap_hit;
    assign vec_accept = idle & vec_req & ~scalar_req & ~wrap_hit;

    assign vec_err      = err_now;
    assign vec_done     = (state_q == StDone);
    assign stall        = (idle & vec_req & ~err_now) | (state_q == StXfer) | (state_q == StDrain);
    assign scalar_rdata = ram_q;

    always_comb begin
        scalar_gnt = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_wren   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (scalar_req) begin
                    scalar_gnt = 1'b1;
                    ram_addr   = scalar_addr;
                    ram_wdata  = scalar_wdata;
                    ram_wren   = scalar_we;
                end
            end
            StXfer: begin
                ram_addr  = base_q + ADDR_W'(lane_q);
                ram_wdata = wdata_q[LANE_W-1:0];
                ram_wren  = we_q;
            end
            default: ;
        endcase
    end

    // Store data is shifted down one lane per beat so the current byte is always at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cap_en_q   <= 1'b0;
            cap_lane_q <= '0;
        end else begin
            cap_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (vec_accept) begin
                        state_q <= StXfer;
                        lane_q  <= '0;
                        base_q  <= vec_addr;
                        we_q    <= vec_we;
                        wdata_q <= vec_wdata;
                    end
                end
                StXfer: begin
                    cap_en_q   <= ~we_q;
                    cap_lane_q <= lane_q;
                    wdata_q    <= wdata_q >> LANE_W;
                    if (lane_q == LAST_LANE) begin
                        lane_q  <= '0;
                        state_q <= we_q ? StDone : StDrain;
                    end else begin
                        lane_q <= lane_q + IDX_W'(1);
                    end
                end
                StDrain: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    vmem_lane_assembler #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .IDX_W  (IDX_W)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .cap_en    (cap_en_q),
        .lane      (cap_lane_q),
        .lane_byte (ram_q),
        .vec_data  (vec_rdata)
    );

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer with a byte-array reference memory model.
module tb_vector_mem_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         scalar_req = 1'b0, scalar_we = 1'b0;
    logic [7:0]   scalar_addr = '0, scalar_wdata = '0;
    logic         scalar_gnt;
    logic [7:0]   scalar_rdata;
    logic         vec_req = 1'b0, vec_we = 1'b0;
    logic [7:0]   vec_addr = '0;
    logic [127:0] vec_wdata = '0;
    logic [127:0] vec_rdata;
    logic         vec_done, vec_err, stall;
    logic [7:0]   ram_addr, ram_wdata;
    logic         ram_wren;
    logic [7:0]   ram_q = '0;

    logic [7:0]   ram [256];
    logic [7:0]   ref_mem [256];
    logic         pre_we = 1'b0;
    logic [7:0]   pre_addr = '0, pre_data = '0;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic [127:0] last_load = '0;
    bit           rd_pend = 1'b0;
    logic [7:0]   rd_exp = '0;

    typedef struct {
        bit           is_err;
        logic [127:0] rdata;
        int           done_cyc;
        int           stalls;
    } vexp_t;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         stall;
    } sexp_t;

    vexp_t vq[$];
    sexp_t sq[$];

    vector_mem_sequencer #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .scalar_req   (scalar_req),
        .scalar_we    (scalar_we),
        .scalar_addr  (scalar_addr),
        .scalar_wdata (scalar_wdata),
        .scalar_gnt   (scalar_gnt),
        .scalar_rdata (scalar_rdata),
        .vec_req      (vec_req),
        .vec_we       (vec_we),
        .vec_addr     (vec_addr),
        .vec_wdata    (vec_wdata),
        .vec_rdata    (vec_rdata),
        .vec_done     (vec_done),
        .vec_err      (vec_err),
        .stall        (stall),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, done or error.
    always @(negedge clk) begin
        sexp_t s;
        vexp_t v;
        if (reset) begin
            stall_cnt = 0;
            rd_pend   = 1'b0;
        end else begin
            if (stall) stall_cnt++;
            if (rd_pend) begin
                chk("scalar_rdata", scalar_rdata, rd_exp);
                rd_pend = 1'b0;
            end
            if (scalar_gnt) begin
                if (sq.size() == 0) begin
                    chk("unexpected_scalar_gnt", scalar_gnt, 0);
                end else begin
                    s = sq.pop_front();
                    chk("scalar_addr", ram_addr, s.addr);
                    chk("scalar_wren", ram_wren, s.we);
                    chk("scalar_stall", stall, s.stall);
                    if (s.we) chk("scalar_wdata", ram_wdata, s.wdata);
                    else begin
                        rd_pend = 1'b1;
                        rd_exp  = s.rdata;
                    end
                end
            end
            if (vec_done || vec_err) begin
                if (vq.size() == 0) begin
                    chk("unexpected_vec_event", {vec_done, vec_err}, 0);
                end else begin
                    v = vq.pop_front();
                    chk("vec_err", vec_err, v.is_err);
                    chk("vec_done", vec_done, !v.is_err);
                    chk("vec_rdata", vec_rdata, v.rdata);
                    chk("vec_done_cycle", cyc, v.done_cyc);
                    chk("vec_stall_cycles", stall_cnt, v.stalls);
                    if (v.is_err) chk("err_ram_wren", ram_wren, 0);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic scalar_op(input bit we, input logic [7:0] a, input logic [7:0] d);
        sexp_t s;
        scalar_req = 1'b1; scalar_we = we; scalar_addr = a; scalar_wdata = d;
        s.we = we; s.addr = a; s.wdata = d; s.rdata = ref_mem[a]; s.stall = 1'b0;
        sq.push_back(s);
        if (we) ref_mem[a] = d;
        @(posedge clk); #1;
        scalar_req = 1'b0;
    endtask

    // mode 0: vector alone; 1: scalar in the same cycle; 2: scalar raised during the transfer.
    task automatic vec_op(input bit we, input logic [7:0] a, input logic [127:0] wd,
                          input int mode_in, input bit swe, input logic [7:0] sa,
                          input logic [7:0] sd);
        vexp_t v;
        sexp_t s;
        bit    wraps;
        bit    finished;
        int    n;
        int    lat;
        int    mode;
        wraps = (int'(a) + int'(LANES) - 1) > 255;
`ifndef VMEM_WRAP_GUARD_EN
        wraps = 1'b0;
`endif
        mode = (wraps && mode_in == 2) ? 0 : mode_in;
        vec_req = 1'b1; vec_we = we; vec_addr = a; vec_wdata = wd;
        s.we = swe; s.addr = sa; s.wdata = sd; s.rdata = '0;
        if (mode == 1) begin
            scalar_req = 1'b1; scalar_we = swe; scalar_addr = sa; scalar_wdata = sd;
            s.rdata = ref_mem[sa]; s.stall = 1'b1;
            sq.push_back(s);
            if (swe) ref_mem[sa] = sd;
        end
        lat = (mode == 1) ? 1 : 0;
        v.is_err = wraps;
        if (!wraps) begin
            lat += we ? 17 : 18;
            for (int i = 0; i < 16; i++) begin
                if (we) ref_mem[8'(int'(a) + i)] = wd[i*8 +: 8];
                else last_load[i*8 +: 8] = ref_mem[8'(int'(a) + i)];
            end
        end
        v.rdata = last_load; v.done_cyc = cyc + lat; v.stalls = lat;
        vq.push_back(v);
        finished = 1'b0;
        n = 0;
        while (!finished && n < 40) begin
            @(negedge clk);
            if (vec_done || vec_err) finished = 1'b1;
            if (mode == 2 && scalar_req) chk("scalar_blocked_in_xfer", scalar_gnt, 0);
            @(posedge clk); #1;
            n++;
            if (mode == 1 && n == 1) scalar_req = 1'b0;
            if (mode == 2 && n == 3 && !finished) begin
                scalar_req = 1'b1; scalar_we = swe; scalar_addr = sa; scalar_wdata = sd;
                s.rdata = ref_mem[sa]; s.stall = 1'b0;
                sq.push_back(s);
                if (swe) ref_mem[sa] = sd;
            end
        end
        chk("vec_completed", finished, 1);
        vec_req = 1'b0;
        if (mode == 2) begin
            @(posedge clk); #1;
            scalar_req = 1'b0;
        end
    endtask

    task automatic reset_mid_store(input logic [7:0] a, input logic [127:0] wd);
        vec_req = 1'b1; vec_we = 1'b1; vec_addr = a; vec_wdata = wd;
        repeat (6) begin
            @(posedge clk); #1;
        end
        // Now in the beat writing lane 5; reset lands after that byte is committed.
        reset = 1'b1; vec_req = 1'b0;
        for (int i = 0; i < 6; i++) ref_mem[8'(int'(a) + i)] = wd[i*8 +: 8];
        last_load = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_wren", ram_wren, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_rdata", vec_rdata, 0);
        chk("rst_mid_done", vec_done, 0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            pre_we = 1'b1; pre_addr = 8'(i); pre_data = 8'($urandom);
            ref_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        chk("rst_scalar_gnt", scalar_gnt, 0);
        chk("rst_vec_done", vec_done, 0);
        chk("rst_vec_err", vec_err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_vec_rdata", vec_rdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        vec_op(1'b1, 8'h10, 128'h0F0E0D0C0B0A09080706050403020100, 0, 1'b0, 8'h0, 8'h0);
        vec_op(1'b0, 8'h10, '0, 0, 1'b0, 8'h0, 8'h0);
        vec_op(1'b1, 8'h60, {4{32'hA5C3_1E77}}, 1, 1'b1, 8'h40, 8'h55);
        scalar_op(1'b0, 8'h40, 8'h00);
        vec_op(1'b0, 8'hF8, '0, 0, 1'b0, 8'h0, 8'h0);
        vec_op(1'b0, 8'h10, '0, 0, 1'b0, 8'h0, 8'h0);
        reset_mid_store(8'h80, {$urandom, $urandom, $urandom, $urandom});
        vec_op(1'b0, 8'h80, '0, 0, 1'b0, 8'h0, 8'h0);
        vec_op(1'b1, 8'h20, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 8'h22, 8'h0);
        vec_op(1'b0, 8'h30, '0, 2, 1'b1, 8'h35, 8'h9C);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                scalar_op(1'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                vec_op(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom},
                       $urandom_range(0, 2), 1'($urandom), 8'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("vec_queue_empty", vq.size(), 0);
        chk("scalar_queue_empty", sq.size(), 0);
        for (int i = 0; i < 256; i++) chk("ram_image", ram[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Serializes 128-bit vector loads/stores into sixteen byte-wide accesses on the single 8-bit data RAM port, and arbitrates that port against scalar loads/stores from the Memory stage. Sits between the ExecuteMemory register outputs and the RAM. It stalls the pipeline while a vector transfer is in flight and reassembles load bytes into a 128-bit result for the MemoryWriteback register.

## Interface
Parameters:
- ADDR_W, 8, RAM byte address width
- LANES, 16, bytes per vector
- LANE_W, 8, bits per lane; vector width is LANES*LANE_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scalar_req  in  1  scalar load/store present in Memory stage
- scalar_we  in  1  scalar store when 1
- scalar_addr  in  ADDR_W  scalar byte address
- scalar_wdata  in  LANE_W  scalar store data
- scalar_gnt  out  1  scalar access owns RAM port this cycle
- scalar_rdata  out  LANE_W  ram_q passthrough, valid the cycle after grant
- vec_req  in  1  vector load/store present in Memory stage
- vec_we  in  1  vector store when 1
- vec_addr  in  ADDR_W  vector base byte address
- vec_wdata  in  LANES*LANE_W  vector store data, lane i = bits [8i+7:8i]
- vec_rdata  out  LANES*LANE_W  assembled load data
- vec_done  out  1  one-cycle pulse, transfer complete
- vec_err  out  1  one-cycle pulse, request rejected (see Configuration)
- stall  out  1  hold Fetch..Memory stages
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  LANE_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  LANE_W  RAM read data, one-cycle latency after address

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- IDLE: if scalar_req, scalar_gnt=1, RAM driven from scalar_* (wren=scalar_we); vec_req in the same cycle is not accepted (scalar has priority; request stays pending, stall=1). Else if vec_req: latch base, we, wdata; lane=0; go XFER. No request: ram_wren=0.
- XFER: ram_addr = base+lane mod 2^ADDR_W; ram_wren=we; ram_wdata=latched lane byte; lane++. At lane==LANES-1: store -> DONE, load -> DRAIN. scalar_gnt=0.
- Load capture: byte issued at lane i is written into vec_rdata[8i+7:8i] the following cycle (XFER for i<15, DRAIN for i=15).
- DONE: vec_done=1, stall=0, vec_rdata stable; unconditionally -> IDLE (the same instruction leaves Memory stage at this edge; never re-accepted).
- stall = (IDLE & vec_req) | XFER | DRAIN.
- vec_rdata holds until next vector load begins capture; store leaves it unchanged.

## Timing
- Cycle 0 = IDLE with vec_req and no scalar_req. Store: XFER cycles 1-16, DONE cycle 17; stall high cycles 0-16. Load: XFER 1-16, DRAIN 17, DONE 18; stall high 0-17.
- Scalar access: zero added latency, never stalls when no vector is active.
- Reset (any state, including mid-XFER): next cycle state=IDLE, lane=0, ram_wren=0, vec_rdata=0, vec_done=0, vec_err=0, scalar_gnt=0; partially written bytes stay in RAM, no done pulse.
- Reset values: all outputs 0.

## Configuration
- VMEM_WRAP_GUARD_EN defined: in IDLE, a vec_req with vec_addr+LANES-1 > 2^ADDR_W-1 is rejected: no RAM access, vec_err=1 and stall=0 for that one cycle, stays IDLE, vec_rdata unchanged.
- Undefined: addresses wrap modulo 2^ADDR_W; vec_err tied 0.

## Structure
- Package vmem_pkg: state enum vmem_state_t, LANES, LANE_W, VEC_W constants.
- One sub-module vmem_lane_assembler: lane-indexed byte capture register for vec_rdata (clk, reset, capture enable, lane index, byte in).

## Test plan
- Store: vec_req, we=1, addr=0x10, wdata=0x0F0E..0100 -> 16 writes 0x10..0x1F with bytes 0x00..0x0F, done at cycle 17, stall high 17 cycles.
- Load back addr=0x10 -> vec_rdata=0x0F0E..0100, done cycle 18, stall high 18 cycles.
- Scalar and vector same cycle (scalar store 0x55 @0x40) -> scalar granted cycle 0, vector starts cycle 1, done cycle 18.
- Base 0xF8 load: without macro addresses 0xF8..0xFF,0x00..0x07; with VMEM_WRAP_GUARD_EN -> vec_err pulse, no RAM access.
- Reset asserted at lane 5 of a store -> ram_wren=0 next cycle, IDLE, no vec_done; only bytes 0-5 written.
- scalar_req during XFER -> scalar_gnt=0, stall held, scalar served after DONE.
